vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA raster timing generator, successor to the fixed 50 MHz generator.
- Produces h/v sync, visible-area flag, pixel coordinates and frame/line strobes for any mode set by parameters.
- Optional pixel-clock divide from the system clock.
- Sits between the board clock and the pixel/framebuffer logic of the display path.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- H_SYNC_POL, 1, active level of h_synk (1 = active-high)
- V_SYNC_POL, 1, active level of v_synk
- CLK_DIV, 1, system clocks per pixel (1..16)
- CW, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk, in, 1, system clock (50 MHz nominal)
- rst_n, in, 1, asynchronous active-low reset
- restart, in, 1, synchronous request to restart the raster at (0,0)
- h_synk, out, 1, horizontal sync, registered
- v_synk, out, 1, vertical sync, registered
- x_pos, out, CW, visible-area column; 0 outside the visible area
- y_pos, out, CW, visible-area row; 0 outside the visible area
- display_zone, out, 1, 1 when the current pixel is visible
- pix_valid, out, 1, single-cycle strobe on the first clock a new pixel is presented
- line_start, out, 1, pix_valid qualified with h=0
- frame_start, out, 1, pix_valid qualified with h=0 and v=0

Behaviour:
- H_TOTAL = sum of the four H parameters (default 1040); V_TOTAL = sum of the four V parameters (default 666).
- Divider div_cnt runs 0..CLK_DIV-1 and wraps. tick = (div_cnt == CLK_DIV-1); with CLK_DIV=1, tick is constant 1.
- h_cnt advances on tick and wraps from H_TOTAL-1 to 0.
- v_cnt advances on tick only when h_cnt wraps, and wraps from V_TOTAL-1 to 0.
- Output stage: every output is registered from the current (div_cnt, h_cnt, v_cnt), so each output lags its counter by exactly 1 clock. All outputs are mutually aligned.
- display_zone = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- x_pos = h_cnt and y_pos = v_cnt when visible, else 0.
- h_synk is at the active level for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 856..975); otherwise inactive.
- v_synk is at the active level for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 637..642); otherwise inactive.
- pix_valid = registered (div_cnt == 0). Each coordinate is held for CLK_DIV clocks.
- Reset (async assert, sync release):
  - div_cnt, h_cnt, v_cnt = 0.
  - h_synk = !H_SYNC_POL; v_synk = !V_SYNC_POL.
  - x_pos, y_pos, display_zone, pix_valid, line_start, frame_start = 0.
- First clock after release: outputs reflect (0,0), i.e. display_zone=1, pix_valid=1, frame_start=1.
- restart: on the next clock, div_cnt, h_cnt and v_cnt load 0, regardless of tick or wrap. restart has priority over a simultaneous wrap. The clock after that presents (0,0) with frame_start=1.
- Reset asserted mid-frame forces the reset values immediately; no partial-line recovery.
- Parameter check: elaboration fails if CLK_DIV<1, any porch/sync parameter is 0, or 2^CW < H_TOTAL or V_TOTAL.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined: adds output frame_cnt [15:0], reset to 0.
  - Increments by 1 on each clock where frame_start is asserted, wrapping 65535->0.
  - The increment lands on the clock after frame_start, so the reset-release frame reads 1.
  - restart does not clear frame_cnt.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, default params, CLK_DIV=1, run 2 frames -> frame_start period 692640 clocks; line_start period 1040 clocks; display_zone high 800 of every 1040 clocks on lines 0..599 only.
- Same config, probe line 0 -> h_synk high exactly for x-count 856..975 (120 clocks), low elsewhere; v_synk high exactly on lines 637..642 (6 lines).
- CLK_DIV=2 -> each x_pos value held 2 clocks; pix_valid toggles 1,0; frame period 1385280 clocks; x_pos runs 0..799 then 0 during blanking.
- Pulse restart at h=500, v=300 -> next-but-one clock shows x_pos=0, y_pos=0, frame_start=1; a restart coinciding with the h/v wrap gives (0,0) exactly once.
- Assert rst_n low mid-line -> outputs take reset values with no clock edge; release -> frame_start=1 on the first clock; H_SYNC_POL=0 build shows h_synk=1 in reset and low during 856..975.
- VGA_FRAME_COUNT_EN defined, run 3 frames -> frame_cnt reads 1,2,3; restart leaves the count intact and increments once at the forced frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator; optional 16-bit frame counter under VGA_FRAME_COUNT_EN.
// Latency: all outputs registered, one clock behind the counters; free-running, no backpressure.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 56,
  parameter int H_SYNC     = 120,
  parameter int H_BP       = 64,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 37,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 23,
  parameter int H_SYNC_POL = 1,
  parameter int V_SYNC_POL = 1,
  parameter int CLK_DIV    = 1,
  parameter int CW         = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  output logic          h_synk,
  output logic          v_synk,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          display_zone,
  output logic          pix_valid,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ACT   = (H_SYNC_POL != 0);
  localparam logic          VS_ACT   = (V_SYNC_POL != 0);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be 1..16");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  if ((64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for the raster totals");
  end

  typedef struct packed {
    logic          h_synk;
    logic          v_synk;
    logic [CW-1:0] x_pos;
    logic [CW-1:0] y_pos;
    logic          display_zone;
    logic          pix_valid;
    logic          line_start;
    logic          frame_start;
  } raster_t;

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;
  raster_t       raster_nxt;
  raster_t       raster_q;

  assign tick   = (div_cnt == DIV_LAST);
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // restart wins over any tick or wrap so the next pixel is always (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (restart) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_comb begin
    raster_nxt              = '0;
    raster_nxt.display_zone = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    raster_nxt.x_pos        = raster_nxt.display_zone ? h_cnt : '0;
    raster_nxt.y_pos        = raster_nxt.display_zone ? v_cnt : '0;
    raster_nxt.h_synk       = ((h_cnt >= HS_BEG) && (h_cnt <= HS_END)) ? HS_ACT : ~HS_ACT;
    raster_nxt.v_synk       = ((v_cnt >= VS_BEG) && (v_cnt <= VS_END)) ? VS_ACT : ~VS_ACT;
    raster_nxt.pix_valid    = (div_cnt == '0);
    raster_nxt.line_start   = raster_nxt.pix_valid && (h_cnt == '0);
    raster_nxt.frame_start  = raster_nxt.line_start && (v_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raster_q        <= '0;
      raster_q.h_synk <= ~HS_ACT;
      raster_q.v_synk <= ~VS_ACT;
    end else begin
      raster_q <= raster_nxt;
    end
  end

  assign h_synk       = raster_q.h_synk;
  assign v_synk       = raster_q.v_synk;
  assign x_pos        = raster_q.x_pos;
  assign y_pos        = raster_q.y_pos;
  assign display_zone = raster_q.display_zone;
  assign pix_valid    = raster_q.pix_valid;
  assign line_start   = raster_q.line_start;
  assign frame_start  = raster_q.frame_start;

`ifdef VGA_FRAME_COUNT_EN
  // counts presented frame strobes, so the first frame after reset reads 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (raster_q.frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken mode: cycle-by-cycle model compare plus hand-computed literals.
// Two instances: pixel clock = system clock, and divide-by-2 with active-low syncs.
module tb_vga_timing_gen;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 2;
  localparam int VA = 5, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;   // 15
  localparam int VT = VA + VFP + VSW + VBP;   // 9

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [4:0] x;
    logic [4:0] y;
    logic       dz;
    logic       pv;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic restart;
  logic cmp_en = 1'b0;

  logic       d0_hs, d0_vs, d0_dz, d0_pv, d0_ls, d0_fs;
  logic [4:0] d0_x, d0_y;
  logic       d1_hs, d1_vs, d1_dz, d1_pv, d1_ls, d1_fs;
  logic [4:0] d1_x, d1_y;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] d0_fc, d1_fc;
`endif

  int cmp_n = 0;
  int err_n = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .CLK_DIV(1), .CW(5)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .h_synk(d0_hs), .v_synk(d0_vs), .x_pos(d0_x), .y_pos(d0_y),
    .display_zone(d0_dz), .pix_valid(d0_pv), .line_start(d0_ls), .frame_start(d0_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(d0_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .CLK_DIV(2), .CW(5)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .h_synk(d1_hs), .v_synk(d1_vs), .x_pos(d1_x), .y_pos(d1_y),
    .display_zone(d1_dz), .pix_valid(d1_pv), .line_start(d1_ls), .frame_start(d1_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(d1_fc)
`endif
  );

  // Outputs presented for the n-th system clock since the raster origin.
  function automatic obs_t model(input longint n, input int div, input logic hpol, input logic vpol);
    obs_t   o;
    longint p;
    int     h, v;
    p    = (n / div) % (HT * VT);
    h    = int'(p % HT);
    v    = int'(p / HT);
    o.dz = (h < HA) && (v < VA);
    o.x  = o.dz ? 5'(h) : 5'd0;
    o.y  = o.dz ? 5'(v) : 5'd0;
    o.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? hpol : ~hpol;
    o.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? vpol : ~vpol;
    o.pv = ((n % div) == 0);
    o.ls = o.pv && (h == 0);
    o.fs = o.ls && (v == 0);
    return o;
  endfunction

  function automatic obs_t reset_obs(input logic hpol, input logic vpol);
    obs_t o;
    o    = '0;
    o.hs = ~hpol;
    o.vs = ~vpol;
    return o;
  endfunction

  longint n0, n1;
  obs_t   e0, e1, a0, a1;
  int     fc0, fc1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n0  = 0;
      n1  = 0;
      e0  = reset_obs(1'b1, 1'b1);
      e1  = reset_obs(1'b0, 1'b0);
      fc0 = 0;
      fc1 = 0;
    end else begin
      if (e0.fs) fc0 = (fc0 + 1) % 65536;
      if (e1.fs) fc1 = (fc1 + 1) % 65536;
      e0 = model(n0, 1, 1'b1, 1'b1);
      e1 = model(n1, 2, 1'b0, 1'b0);
      if (restart) begin
        n0 = 0;
        n1 = 0;
      end else begin
        n0++;
        n1++;
      end
    end
  end

  assign a0 = '{hs: d0_hs, vs: d0_vs, x: d0_x, y: d0_y, dz: d0_dz, pv: d0_pv, ls: d0_ls, fs: d0_fs};
  assign a1 = '{hs: d1_hs, vs: d1_vs, x: d1_x, y: d1_y, dz: d1_dz, pv: d1_pv, ls: d1_ls, fs: d1_fs};

  task automatic check(input string name, input longint act, input longint exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("dut0 outputs", longint'(a0), longint'(e0));
      check("dut1 outputs", longint'(a1), longint'(e1));
`ifdef VGA_FRAME_COUNT_EN
      check("dut0 frame_cnt", longint'(d0_fc), longint'(fc0));
      check("dut1 frame_cnt", longint'(d1_fc), longint'(fc1));
`endif
    end
  end

  // Starts on a dut0 frame_start sample; returns at the next one.
  task automatic scan_frame(input bit first, input int fc_exp, output int period, output int dz_n,
                            output int hs_first, output int hs_n, output int ls_n, output int fs1_n);
    period   = 0;
    dz_n     = d0_dz ? 1 : 0;
    ls_n     = d0_ls ? 1 : 0;
    hs_first = -1;
    hs_n     = 0;
    fs1_n    = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      period = i;
      if (d1_fs) fs1_n++;
      if (d0_fs) break;
      if (d0_dz) dz_n++;
      if (d0_ls) ls_n++;
      if (i < HT && d0_hs) begin
        if (hs_first < 0) hs_first = i;
        hs_n++;
      end
      if (first && i == 1) begin
        check("div2 pix_valid idx1", longint'(d1_pv), 0);
        check("div2 x_pos idx1", longint'(d1_x), 0);
      end
      if (first && i == 2) begin
        check("div2 pix_valid idx2", longint'(d1_pv), 1);
        check("div2 x_pos idx2", longint'(d1_x), 1);
      end
`ifdef VGA_FRAME_COUNT_EN
      if (i == 1) check("frame_cnt after frame_start", longint'(d0_fc), longint'(fc_exp));
`endif
    end
  endtask

  initial begin
    int period, dz_n, hs_first, hs_n, ls_n, fs1_n, found, fs_cnt, fs_first;
    restart = 1'b0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #2;
    check("reset h_synk pol1", longint'(d0_hs), 0);
    check("reset h_synk pol0", longint'(d1_hs), 1);
    check("reset display_zone", longint'(d0_dz), 0);
    check("reset pix_valid", longint'(d0_pv), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    check("first clock frame_start", longint'(d0_fs), 1);
    check("first clock display_zone", longint'(d0_dz), 1);
    check("first clock div2 frame_start", longint'(d1_fs), 1);

    scan_frame(1'b1, 1, period, dz_n, hs_first, hs_n, ls_n, fs1_n);
    check("frame period", period, 135);
    check("visible clocks per frame", dz_n, 40);
    check("h_synk first index", hs_first, 10);
    check("h_synk width", hs_n, 3);
    check("lines per frame", ls_n, 9);
    check("div2 frame_start in frame 1", fs1_n, 0);

    scan_frame(1'b0, 2, period, dz_n, hs_first, hs_n, ls_n, fs1_n);
    check("frame period 2", period, 135);
    check("div2 frame period", fs1_n, 1);
    @(negedge clk);
`ifdef VGA_FRAME_COUNT_EN
    check("frame_cnt third frame", longint'(d0_fc), 3);
`endif

    found = 0;
    for (int i = 0; i < 300; i++) begin
      if (d0_x == 5'd5 && d0_y == 5'd3) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("reached (5,3)", found, 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
    check("restart x_pos", longint'(d0_x), 0);
    check("restart y_pos", longint'(d0_y), 0);
    check("restart frame_start", longint'(d0_fs), 1);

    // restart exactly as the counters sit on the last pixel of the frame
    repeat (133) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    fs_cnt   = 0;
    fs_first = -1;
    for (int i = 1; i <= 135; i++) begin
      @(negedge clk);
      if (d0_fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
      end
    end
    check("wrap restart frame_start count", fs_cnt, 1);
    check("wrap restart frame_start offset", fs_first, 1);

    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset h_synk", longint'(d0_hs), 0);
    check("async reset display_zone", longint'(d0_dz), 0);
    check("async reset x_pos", longint'(d0_x), 0);
    check("async reset h_synk pol0", longint'(d1_hs), 1);
`ifdef VGA_FRAME_COUNT_EN
    check("async reset frame_cnt", longint'(d0_fc), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("re-release frame_start", longint'(d0_fs), 1);
    check("re-release div2 frame_start", longint'(d1_fs), 1);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
